muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port: clock  in  1  single rising-edge clock.
REQ-002 SHALL have port: resetn  in  1  asynchronous active-low reset.
REQ-003 SHALL have port: start  in  1  request; accepted only while busy=0.
REQ-004 SHALL have port: op  in  2  operation: 00 MUL (low 32 of product), 01 MULHU (high 32, unsigned), 10 DIVU, 11 REMU.
REQ-005 SHALL have port: OpA, OpB  in  32 each  operands, unsigned.
REQ-006 SHALL have port: rd  in  6  destination register index.
REQ-007 SHALL have port: busy  out  1  high from acceptance until the result cycle ends.
REQ-008 SHALL have port: WriteReg  out  6  destination index to the register file.
REQ-009 SHALL have port: WriteData  out  32  result to the register file.
REQ-010 SHALL have port: RegWrite  out  1  one-cycle write strobe to the register file.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-012 In IDLE, start=1 at a rising edge (E0) SHALL latch op, OpA, OpB and rd, clear the 6-bit iteration counter, and enter RUN.
REQ-013 In RUN, each edge SHALL perform exactly one iteration: radix-2 shift-add for MUL/MULHU, or restoring shift-subtract for DIVU/REMU.
REQ-014 After 32 iterations (edges E1..E32) the FSM SHALL enter DONE.
REQ-015 DONE SHALL last one cycle (between E32 and E33) with RegWrite=1 and valid WriteReg/WriteData; the FSM SHALL return to IDLE at E33.
REQ-016 Latency SHALL be fixed for all ops and operands; the next start is accepted no earlier than E33.
REQ-017 busy SHALL be high from E0 to E33; start while busy=1 SHALL be ignored, not queued.
REQ-018 Input changes after E0 SHALL NOT affect the in-flight result.
REQ-019 Product SHALL be held in a 64-bit accumulator; MUL returns bits [31:0], MULHU returns bits [63:32].
REQ-020 Division SHALL use a 33-bit partial remainder; DIVU returns the quotient, REMU the remainder.
REQ-021 Divide by zero SHALL yield quotient 0xFFFFFFFF and remainder OpA, produced by the normal iteration with no special-case path.
REQ-022 When rd=0, RegWrite SHALL stay 0 in DONE; the timing and busy behaviour are unchanged.
REQ-023 Outside DONE, RegWrite SHALL be 0, and WriteReg and WriteData SHALL be 0.

Reset
REQ-024 resetn=0 SHALL asynchronously force IDLE, counter 0, busy=0, RegWrite=0, WriteReg=0 and WriteData=0.
REQ-025 Reset during RUN or DONE SHALL discard the operation, and no RegWrite SHALL follow.
REQ-026 The first start SHALL be accepted at the first rising edge after resetn deasserts.

Structure
REQ-027 A shared package muldiv_pkg SHALL hold: XLEN=32, REGIDX_W=6, ITERATIONS=32, the op encodings and the FSM state typedef.
REQ-028 A single combinational sub-module muldiv_step SHALL compute one iteration (next accumulator/remainder and quotient bit) and be instantiated once.
REQ-029 All state SHALL reside in muldiv_unit; no RAM or multiplier macro SHALL be used.

Verification
REQ-030 MUL: 7 x 6, rd=5 -> RegWrite exactly one cycle after E32, WriteReg=5, WriteData=42.
REQ-031 MULHU: 0xFFFFFFFF x 0xFFFFFFFF -> WriteData=0xFFFFFFFE; MUL on the same operands -> 0x00000001.
REQ-032 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
REQ-033 rd=0 MUL 3 x 3 -> busy high 33 cycles, RegWrite never asserted.
REQ-034 start pulsed at E10 during a DIVU -> ignored: single RegWrite at E32 with the original result.
REQ-035 resetn low at E15 of a MUL -> outputs 0 immediately, no RegWrite; a new start after release completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared widths, op encodings and FSM state type for the iterative mul/div unit.
package muldiv_pkg;

    localparam int XLEN       = 32;
    localparam int REGIDX_W   = 6;
    localparam int ITERATIONS = 32;

    localparam logic [5:0] LAST_ITER = 6'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic is_div(input op_t op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: LSB-first shift-add multiply step and
// restoring shift-subtract divide step.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN:0]     rem,
    input  logic [XLEN-1:0]   operand_b,
    output logic [2*XLEN-1:0] prod_next,
    output logic [XLEN:0]     rem_next,
    output logic              q_bit
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] divisor;

    always_comb begin
        sum       = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand_b} : '0);
        prod_next = {sum, acc[XLEN-1:1]};

        // rem[XLEN] set means the true shifted value exceeds any 32-bit divisor
        shifted  = {rem[XLEN-1:0], acc[XLEN-1]};
        divisor  = {1'b0, operand_b};
        q_bit    = rem[XLEN] || (shifted >= divisor);
        rem_next = q_bit ? (shifted - divisor) : shifted;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Fixed-latency iterative multiply/divide unit with a register-file write port.
//
// state | meaning
// IDLE  | waiting for start; outputs zero
// RUN   | one mul/div iteration per clock, 32 in total
// DONE  | result cycle; RegWrite strobes unless rd is 0
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [XLEN-1:0]     OpA,
    input  logic [XLEN-1:0]     OpB,
    input  logic [REGIDX_W-1:0] rd,
    output logic                busy,
    output logic [REGIDX_W-1:0] WriteReg,
    output logic [XLEN-1:0]     WriteData,
    output logic                RegWrite
);

    state_t              state;
    op_t                 op_q;
    logic [REGIDX_W-1:0] rd_q;
    logic [XLEN-1:0]     b_q;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN:0]       rem;
    logic [5:0]          cnt;

    logic [2*XLEN-1:0]   prod_next;
    logic [XLEN:0]       rem_next;
    logic                q_bit;
    logic [2*XLEN-1:0]   acc_next;
    logic [XLEN-1:0]     result;

    muldiv_step u_step (
        .acc       (acc),
        .rem       (rem),
        .operand_b (b_q),
        .prod_next (prod_next),
        .rem_next  (rem_next),
        .q_bit     (q_bit)
    );

    // for division the low half of acc shifts the dividend out and the quotient in
    always_comb begin
        acc_next = is_div(op_q) ? {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], q_bit} : prod_next;
        unique case (op_q)
            OP_MUL:   result = acc_next[XLEN-1:0];
            OP_MULHU: result = acc_next[2*XLEN-1:XLEN];
            OP_DIVU:  result = acc_next[XLEN-1:0];
            default:  result = rem_next[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            op_q      <= OP_MUL;
            rd_q      <= '0;
            b_q       <= '0;
            acc       <= '0;
            rem       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
            RegWrite  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q  <= op_t'(op);
                        rd_q  <= rd;
                        b_q   <= OpB;
                        acc   <= {{XLEN{1'b0}}, OpA};
                        rem   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc <= acc_next;
                    rem <= rem_next;
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST_ITER) begin
                        WriteReg  <= rd_q;
                        WriteData <= result;
                        RegWrite  <= (rd_q != '0);
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    WriteReg  <= '0;
                    WriteData <= '0;
                    RegWrite  <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: stimulus pushes expected writes into a queue,
// a negedge monitor pops and compares every RegWrite.
module tb_muldiv_unit;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic [5:0]  rd;
    logic        busy;
    logic [5:0]  WriteReg;
    logic [31:0] WriteData;
    logic        RegWrite;

    typedef struct {
        logic [5:0]  rd;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    muldiv_unit dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .op        (op),
        .OpA       (OpA),
        .OpB       (OpB),
        .rd        (rd),
        .busy      (busy),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .RegWrite  (RegWrite)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (resetn === 1'b1 && RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: actual reg=%0d data=0x%0h required=no write", WriteReg, WriteData);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_reg"}, 64'(WriteReg), 64'(e.rd));
                check({e.name, "_data"}, 64'(WriteData), 64'(e.data));
            end
        end
    end

    // pulse_at: edge index at which a competing start is presented (0 = none)
    // abort_at: edge index after which reset is asserted (0 = none)
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] r, input logic [31:0] expected,
                          input int pulse_at, input int abort_at);
        int   busy_cnt;
        logic early;
        exp_t e;
        busy_cnt = 0;
        early    = 1'b0;
        @(negedge clock);
        op = o; OpA = a; OpB = b; rd = r; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        op = ~o; OpA = 32'hDEAD_BEEF; OpB = 32'h0000_0003; rd = 6'd63;
        if (abort_at == 0 && r != 6'd0) begin
            e.rd = r; e.data = expected; e.name = name;
            exp_q.push_back(e);
        end
        if (busy === 1'b1) busy_cnt++;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clock);
            #1;
            if (busy === 1'b1) busy_cnt++;
            if (i == pulse_at - 1) begin
                start = 1'b1; op = 2'b00; OpA = 32'd5; OpB = 32'd5; rd = 6'd9;
            end
            if (i == pulse_at) start = 1'b0;
            if (abort_at != 0 && i == abort_at) begin
                resetn = 1'b0;
                #1;
                check({name, "_reset_outputs"}, {busy, RegWrite, WriteReg, WriteData},
                      {1'b0, 1'b0, 6'd0, 32'd0});
                repeat (3) @(posedge clock);
                @(negedge clock);
                resetn = 1'b1;
                return;
            end
            if (i < 32 && RegWrite !== 1'b0) early = 1'b1;
        end
        check({name, "_no_early_write"}, 64'(early), 64'd0);
        check({name, "_strobe_after_E32"}, {RegWrite, WriteReg}, {(r != 6'd0), r});
        @(posedge clock);
        #1;
        busy_cnt = busy_cnt;
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({name, "_idle_after_E33"}, {busy, RegWrite, WriteReg, WriteData},
              {1'b0, 1'b0, 6'd0, 32'd0});
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        OpA    = '0;
        OpB    = '0;
        rd     = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_state", {busy, RegWrite, WriteReg, WriteData}, {1'b0, 1'b0, 6'd0, 32'd0});
        @(negedge clock);
        resetn = 1'b1;

        run_op("mul_7x6",        2'b00, 32'd7,          32'd6,          6'd5,  32'd42,         0, 0);
        run_op("mulhu_max",      2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  6'd7,  32'hFFFF_FFFE,  0, 0);
        run_op("mul_max",        2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  6'd8,  32'h0000_0001,  0, 0);
        run_op("mulhu_small",    2'b01, 32'h8000_0000,  32'd4,          6'd12, 32'd2,          0, 0);
        run_op("divu_100_7",     2'b10, 32'd100,        32'd7,          6'd1,  32'd14,         0, 0);
        run_op("remu_100_7",     2'b11, 32'd100,        32'd7,          6'd2,  32'd2,          0, 0);
        run_op("divu_by_zero",   2'b10, 32'h0000_1234,  32'd0,          6'd3,  32'hFFFF_FFFF,  0, 0);
        run_op("remu_by_zero",   2'b11, 32'h0000_1234,  32'd0,          6'd4,  32'h0000_1234,  0, 0);
        run_op("divu_max_1",     2'b10, 32'hFFFF_FFFF,  32'd1,          6'd63, 32'hFFFF_FFFF,  0, 0);
        run_op("remu_big",       2'b11, 32'hFFFF_FFFF,  32'h8000_0000,  6'd10, 32'h7FFF_FFFF,  0, 0);
        run_op("mul_rd0",        2'b00, 32'd3,          32'd3,          6'd0,  32'd9,          0, 0);
        run_op("divu_busy_start",2'b10, 32'd1000,       32'd10,         6'd11, 32'd100,       10, 0);
        run_op("mul_abort",      2'b00, 32'd123,        32'd456,        6'd13, 32'd56088,      0, 15);
        repeat (40) @(negedge clock);
        run_op("mul_after_reset",2'b00, 32'd123,        32'd456,        6'd13, 32'd56088,      0, 0);

        repeat (5) @(posedge clock);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
